glitch_pulse_gen: RTL and testbench
===================================

# glitch_pulse_gen

Trigger-to-glitch timing engine for the glitcher core. It sits between the UART command decoder, which supplies delay/width values and an arm strobe, and the glitch output pins (`pulse_out`, `pulse_en`, `target_reset`). It synchronises the external trigger and waits a programmed number of cycles after a qualifying trigger edge. It then emits one glitch pulse of programmed width and reports completion.

## Interface
- `DELAY_W`, 16: width of the delay value, in cycles.
- `WIDTH_W`, 8: width of the pulse-width value, in cycles.
- `RST_CYCLES`, 64: `target_reset` assertion length; used only when `GLITCH_RESET_SEQ_EN` is defined. Must be ≥1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `trigger_in`  in  1  asynchronous external trigger pin.
- `trig_falling`  in  1  0 = rising-edge trigger, 1 = falling-edge trigger; latched at arm.
- `delay`  in  DELAY_W  cycles from the trigger event to the pulse; latched at arm.
- `width`  in  WIDTH_W  pulse length in cycles; latched at arm.
- `arm`  in  1  single-cycle strobe from the command decoder.
- `abort`  in  1  single-cycle strobe; cancels any operation in progress.
- `pulse_out`  out  1  registered glitch pulse.
- `pulse_en`  out  1  registered; high in ARMED, DELAY and PULSE.
- `target_reset`  out  1  registered target-reset drive.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle strobe when a pulse completes.

## Operation
- Trigger path: two-flop synchroniser (`s1`, `s2`), then a `prev` flop.
  - When `trig_falling`=0, event = `s2 & ~prev`.
  - When `trig_falling`=1, event = `~s2 & prev`.
  - `prev` updates every cycle in every state, so a level that is already active never produces an event; a fresh edge is required.
- States: IDLE, RESET (only when the macro is defined), ARMED, DELAY, PULSE, DONE.
- IDLE
  - `arm`: latch `delay`, `width` and `trig_falling`.
  - Next state is RESET with the macro, ARMED without it.
  - `arm` in any other state is ignored.
- RESET: count `RST_CYCLES` cycles, then go to ARMED. Trigger events in RESET are ignored.
- ARMED: on an event, load the counter with the latched delay.
  - Delay = 0 → PULSE.
  - Delay > 0 → DELAY.
- DELAY: decrement the counter each cycle. When the counter reaches 1, go to PULSE on the next edge.
- PULSE: `pulse_out` is high for exactly the latched width, in cycles, then the state goes to DONE.
  - Width = 0: ARMED/DELAY goes straight to DONE and no pulse is emitted.
- DONE: `done`=1 for one cycle, then IDLE.
- `abort`: from any non-IDLE state, go to IDLE on the next edge with all outputs low. No `done` is issued.
  - `abort` has priority over `arm` and over a trigger event in the same cycle.
- Counters do not wrap. The maximum delay is 2^DELAY_W−1 and the maximum width is 2^WIDTH_W−1.

## Timing
- Reset values:
  - `pulse_out`, `pulse_en`, `target_reset`, `busy`, `done` = 0.
  - State is IDLE; synchroniser flops, `prev` and counters = 0.
- Arm: `arm` high at edge A → `busy`=1 and `pulse_en`=1 (non-macro build) after A.
  - A trigger event in the same cycle as `arm` is ignored.
- Event cycle T is the first cycle in which the event term is true. With delay `d` and width `w` > 0:
  - `pulse_out` rises at edge T+1+d and stays high for `w` cycles.
  - `done` is high in the cycle after `pulse_out` falls.
  - `busy` and `pulse_en` drop together with `done` → IDLE (`pulse_en` low during DONE).
- Pin-to-event latency: 2–3 clock cycles; the synchroniser adds up to one cycle of uncertainty.
- A new `arm` is accepted only from IDLE, i.e. no earlier than the cycle after `done`.
- Reset mid-operation: all outputs go low immediately, asynchronously.

## Configuration
- `GLITCH_RESET_SEQ_EN` defined:
  - `arm` enters RESET.
  - `target_reset`=1 for exactly `RST_CYCLES` cycles, then drops as the state enters ARMED.
  - `pulse_en`=0 during RESET.
  - `abort` during RESET releases `target_reset` on the next edge.
- `GLITCH_RESET_SEQ_EN` not defined: the RESET state is not built, `target_reset` is tied to 0, and `arm` goes directly to ARMED.

## Test plan
- `delay`=10, `width`=5, rising trigger after arm → `pulse_out` high exactly 5 cycles, rising 11 edges after T; one `done` strobe; `busy` low afterwards.
- `delay`=0, `width`=1 → `pulse_out` rises at edge T+1 for 1 cycle.
- `width`=0, `delay`=3 → no `pulse_out`; `done` after the delay expires.
- `trigger_in` held high before arm, `trig_falling`=0 → no event until the trigger goes low then high again. With `trig_falling`=1, the falling edge fires.
- `abort` during DELAY (`delay`=1000), and separately during PULSE (`width`=200) → IDLE on the next edge, `pulse_out` low, no `done`. A second `arm` mid-DELAY is ignored.
- `GLITCH_RESET_SEQ_EN`, `RST_CYCLES`=8 → `target_reset` high 8 cycles after arm; a trigger edge during that window is ignored; the next edge fires.

Source files
------------

// File: rtl/glitch_pulse_gen.sv
// glitch_pulse_gen: trigger-to-glitch timing engine. Synchronises an external
// trigger, waits a latched delay after a qualifying edge, then emits one glitch
// pulse of latched width and strobes done.
// Optional macro GLITCH_RESET_SEQ_EN adds a target-reset phase after arm.
// Ports: clk, rst (async, active high), trigger_in, trig_falling, delay, width,
//        arm, abort -> pulse_out, pulse_en, target_reset, busy, done.
module glitch_pulse_gen #(
    parameter int DELAY_W    = 16,
    parameter int WIDTH_W    = 8,
    parameter int RST_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger_in,
    input  logic               trig_falling,
    input  logic [DELAY_W-1:0] delay,
    input  logic [WIDTH_W-1:0] width,
    input  logic               arm,
    input  logic               abort,
    output logic               pulse_out,
    output logic               pulse_en,
    output logic               target_reset,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

`ifdef GLITCH_RESET_SEQ_EN
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_ARMED, S_DELAY, S_PULSE, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_DELAY, S_PULSE, S_DONE
    } state_t;
`endif

    state_t state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic [WIDTH_W-1:0] wid_q, wid_d;
    logic               fall_q, fall_d;
    logic               s1_q, s2_q, prev_q;
    logic               pulse_out_q, pulse_out_d;
    logic               pulse_en_q, pulse_en_d;
    logic               done_q, done_d;
    logic               evt;
`ifdef GLITCH_RESET_SEQ_EN
    logic [RC_W-1:0]    rcnt_q, rcnt_d;
    logic               trst_q, trst_d;
`endif

    // prev tracks s2 every cycle, so an already-active level never fires
    assign evt = fall_q ? (~s2_q & prev_q) : (s2_q & ~prev_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        wid_d   = wid_q;
        fall_d  = fall_q;
`ifdef GLITCH_RESET_SEQ_EN
        rcnt_d  = rcnt_q;
`endif
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        dly_d  = delay;
                        wid_d  = width;
                        fall_d = trig_falling;
`ifdef GLITCH_RESET_SEQ_EN
                        rcnt_d  = RC_W'(RST_CYCLES);
                        state_d = S_RESET;
`else
                        state_d = S_ARMED;
`endif
                    end
                end
`ifdef GLITCH_RESET_SEQ_EN
                S_RESET: begin
                    if (rcnt_q <= RC_W'(1)) state_d = S_ARMED;
                    else rcnt_d = rcnt_q - RC_W'(1);
                end
`endif
                S_ARMED: begin
                    if (evt) begin
                        if (dly_q != '0) begin
                            state_d = S_DELAY;
                            cnt_d   = CNT_W'(dly_q);
                        end else if (wid_q != '0) begin
                            state_d = S_PULSE;
                            cnt_d   = CNT_W'(wid_q);
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        if (wid_q != '0) begin
                            state_d = S_PULSE;
                            cnt_d   = CNT_W'(wid_q);
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_q <= CNT_W'(1)) state_d = S_DONE;
                    else cnt_d = cnt_q - CNT_W'(1);
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // outputs are registered copies of the next-state decode
        pulse_out_d = (state_d == S_PULSE);
        pulse_en_d  = (state_d == S_ARMED) || (state_d == S_DELAY) ||
                      (state_d == S_PULSE);
        done_d      = (state_d == S_DONE);
`ifdef GLITCH_RESET_SEQ_EN
        trst_d      = (state_d == S_RESET);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dly_q       <= '0;
            wid_q       <= '0;
            fall_q      <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            prev_q      <= 1'b0;
            pulse_out_q <= 1'b0;
            pulse_en_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            wid_q       <= wid_d;
            fall_q      <= fall_d;
            s1_q        <= trigger_in;
            s2_q        <= s1_q;
            prev_q      <= s2_q;
            pulse_out_q <= pulse_out_d;
            pulse_en_q  <= pulse_en_d;
            done_q      <= done_d;
        end
    end

`ifdef GLITCH_RESET_SEQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q <= '0;
            trst_q <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            trst_q <= trst_d;
        end
    end
    assign target_reset = trst_q;
`else
    assign target_reset = 1'b0;
`endif

    assign pulse_out = pulse_out_q;
    assign pulse_en  = pulse_en_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// tb_glitch_pulse_gen: directed table-driven bench for glitch_pulse_gen.
// Edge counts are measured from the posedge after the trigger pin changes.
module tb_glitch_pulse_gen;

    localparam int RSTC = 8;
`ifdef GLITCH_RESET_SEQ_EN
    localparam int ARM_WAIT = RSTC + 3;
    localparam int PEN_ARM  = 0;
    localparam int TRS_ARM  = 1;
`else
    localparam int ARM_WAIT = 3;
    localparam int PEN_ARM  = 1;
    localparam int TRS_ARM  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger_in;
    logic        trig_falling;
    logic [15:0] delay;
    logic [7:0]  width;
    logic        arm;
    logic        abort;
    logic        pulse_out;
    logic        pulse_en;
    logic        target_reset;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    glitch_pulse_gen #(
        .DELAY_W(16),
        .WIDTH_W(8),
        .RST_CYCLES(RSTC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trigger_in(trigger_in),
        .trig_falling(trig_falling),
        .delay(delay),
        .width(width),
        .arm(arm),
        .abort(abort),
        .pulse_out(pulse_out),
        .pulse_en(pulse_en),
        .target_reset(target_reset),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int w;
        bit fall;
        int exp_rise;
        int exp_pulses;
        int exp_done;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int d, input int w, input bit fall);
        trig_falling = fall;
        delay = 16'(d);
        width = 8'(w);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("arm_busy", int'(busy), 1);
        check("arm_pen", int'(pulse_en), PEN_ARM);
        check("arm_trst", int'(target_reset), TRS_ARM);
        repeat (ARM_WAIT) step();
    endtask

    task automatic measure(input string tag, input int e_rise,
                           input int e_pc, input int e_done);
        int rise = -1;
        int dn = -1;
        int pc = 0;
        int dc = 0;
        int lim = e_done + 20;
        for (int k = 1; k <= lim; k++) begin
            step();
            if (pulse_out) begin
                pc++;
                if (rise < 0) rise = k;
            end
            if (done) begin
                dc++;
                if (dn < 0) begin
                    dn = k;
                    check({tag, "_pen_in_done"}, int'(pulse_en), 0);
                    check({tag, "_busy_in_done"}, int'(busy), 1);
                end
            end
            if (dn > 0 && !busy) break;
        end
        check({tag, "_rise"}, rise, e_rise);
        check({tag, "_pulses"}, pc, e_pc);
        check({tag, "_done_edge"}, dn, e_done);
        check({tag, "_done_cnt"}, dc, 1);
        check({tag, "_busy_end"}, int'(busy), 0);
        check({tag, "_pen_end"}, int'(pulse_en), 0);
    endtask

    task automatic count_done(input string tag, input int n);
        int dc = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (done) dc++;
        end
        check(tag, dc, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int cnt;
        vecs[0] = '{d: 10, w: 5,   fall: 1'b0, exp_rise: 13, exp_pulses: 5,   exp_done: 18};
        vecs[1] = '{d: 0,  w: 1,   fall: 1'b0, exp_rise: 3,  exp_pulses: 1,   exp_done: 4};
        vecs[2] = '{d: 3,  w: 0,   fall: 1'b0, exp_rise: -1, exp_pulses: 0,   exp_done: 6};
        vecs[3] = '{d: 2,  w: 3,   fall: 1'b1, exp_rise: 5,  exp_pulses: 3,   exp_done: 8};
        vecs[4] = '{d: 1,  w: 2,   fall: 1'b1, exp_rise: 4,  exp_pulses: 2,   exp_done: 6};
        vecs[5] = '{d: 0,  w: 255, fall: 1'b0, exp_rise: 3,  exp_pulses: 255, exp_done: 258};

        rst = 1'b1;
        trigger_in = 1'b0;
        trig_falling = 1'b0;
        delay = '0;
        width = '0;
        arm = 1'b0;
        abort = 1'b0;
        #22;
        check("rst_pulse_out", int'(pulse_out), 0);
        check("rst_pulse_en", int'(pulse_en), 0);
        check("rst_trst", int'(target_reset), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            trigger_in = vecs[i].fall;
            repeat (4) step();
            do_arm(vecs[i].d, vecs[i].w, vecs[i].fall);
            trigger_in = ~vecs[i].fall;
            measure($sformatf("vec%0d", i), vecs[i].exp_rise,
                    vecs[i].exp_pulses, vecs[i].exp_done);
        end

        // level already high at arm: needs a fresh rising edge
        trigger_in = 1'b1;
        repeat (4) step();
        do_arm(2, 2, 1'b0);
        cnt = 0;
        repeat (10) begin
            step();
            if (pulse_out) cnt++;
        end
        trigger_in = 1'b0;
        repeat (5) begin
            step();
            if (pulse_out) cnt++;
        end
        check("held_no_pulse", cnt, 0);
        check("held_still_busy", int'(busy), 1);
        trigger_in = 1'b1;
        measure("held", 5, 2, 7);

        // abort in DELAY, with an ignored re-arm
        trigger_in = 1'b0;
        repeat (4) step();
        do_arm(1000, 4, 1'b0);
        trigger_in = 1'b1;
        repeat (20) step();
        delay = 16'd0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (5) step();
        check("rearm_no_pulse", int'(pulse_out), 0);
        check("rearm_busy", int'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abd_busy", int'(busy), 0);
        check("abd_pen", int'(pulse_en), 0);
        check("abd_pulse", int'(pulse_out), 0);
        count_done("abd_no_done", 10);

        // abort in PULSE
        trigger_in = 1'b0;
        repeat (4) step();
        do_arm(0, 200, 1'b0);
        trigger_in = 1'b1;
        cnt = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (pulse_out && cnt < 0) cnt = k;
        end
        check("abp_rise", cnt, 3);
        check("abp_high", int'(pulse_out), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abp_pulse", int'(pulse_out), 0);
        check("abp_busy", int'(busy), 0);
        check("abp_pen", int'(pulse_en), 0);
        count_done("abp_no_done", 10);

        // asynchronous reset during a pulse
        trigger_in = 1'b0;
        repeat (4) step();
        do_arm(0, 50, 1'b0);
        trigger_in = 1'b1;
        repeat (8) step();
        check("arst_pre", int'(pulse_out), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pulse", int'(pulse_out), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_pen", int'(pulse_en), 0);
        #3;
        rst = 1'b0;
        step();

`ifdef GLITCH_RESET_SEQ_EN
        // target_reset window; a trigger edge inside it is ignored
        trigger_in = 1'b0;
        repeat (4) step();
        trig_falling = 1'b0;
        delay = 16'd0;
        width = 8'd1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("rs_pen", int'(pulse_en), 0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (target_reset) cnt++;
            if (k == 2) trigger_in = 1'b1;
            step();
        end
        check("rs_len", cnt, RSTC);
        check("rs_no_pulse", int'(pulse_out), 0);
        check("rs_armed_pen", int'(pulse_en), 1);
        trigger_in = 1'b0;
        repeat (4) step();
        trigger_in = 1'b1;
        measure("rs", 3, 1, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
